typing_tracker: RTL

Upstream stage of the text renderers: consumes single-cycle key events from the keyboard decoder and a target word from the word source. It maintains the player's typed buffer in the renderers' packed 25×5-bit letter format, plus the live `correct`/`tot` counts that drive per-character highlighting. It judges each word on Enter and keeps saturating word and error tallies (0–999) for the numeric display.

---
 rtl/typeracer_pkg.sv | 29 ++
 rtl/typing_tracker_if.sv | 34 +++
 rtl/typing_tracker_sat_counter.sv | 25 ++
 rtl/typing_tracker.sv | 130 +++++++++++++
 4 files changed

// File: rtl/typeracer_pkg.sv
// Shared definitions for the typing game datapath and the text renderers.
// Packed text layout: char i lives at bits [CODE_W*i +: CODE_W], code 0 = blank,
// codes 1..26 = A..Z.
package typeracer_pkg;

  localparam int unsigned MAX_LEN = 25;
  localparam int unsigned CODE_W  = 5;
  localparam int unsigned CNT_MAX = 999;
  localparam int unsigned CNT_W   = 10;
  localparam int unsigned TOT_W   = 6;
  localparam int unsigned LEN_W   = 5;
  localparam int unsigned TEXT_W  = MAX_LEN * CODE_W;

  localparam logic [CODE_W-1:0] BLANK      = '0;
  localparam logic [CODE_W-1:0] CODE_FIRST = 5'd1;
  localparam logic [CODE_W-1:0] CODE_LAST  = 5'd26;

  typedef logic [TEXT_W-1:0] text_t;

  typedef enum logic [0:0] {
    StIdle,
    StTyping
  } state_e;

  function automatic logic is_letter(input logic [CODE_W-1:0] code);
    return (code >= CODE_FIRST) && (code <= CODE_LAST);
  endfunction

endpackage

// File: rtl/typing_tracker_if.sv
// Bus between the word source / keyboard decoder and the typing tracker.
// master: the producer side (drives load/target/keys, observes results).
// slave:  the tracker itself.
interface typing_tracker_if;
  import typeracer_pkg::*;

  logic                load;
  text_t               target;
  logic [LEN_W-1:0]    target_len;
  logic                key_valid;
  logic [CODE_W-1:0]   key_code;
  logic                key_bs;
  logic                key_enter;

  text_t               typed;
  logic [TOT_W-1:0]    tot;
  logic [TOT_W-1:0]    correct;
  logic                word_ok;
  logic                word_fail;
  logic [CNT_W-1:0]    words;
  logic [CNT_W-1:0]    errors;
  logic                active;

  modport master (
    output load, target, target_len, key_valid, key_code, key_bs, key_enter,
    input  typed, tot, correct, word_ok, word_fail, words, errors, active
  );

  modport slave (
    input  load, target, target_len, key_valid, key_code, key_bs, key_enter,
    output typed, tot, correct, word_ok, word_fail, words, errors, active
  );

endinterface

// File: rtl/typing_tracker_sat_counter.sv
// sat_counter: up-counter that holds at Max. Cleared only by rst_n (async, low).
// Ports: clk, rst_n, inc (count enable), count (current value).
module sat_counter #(
  parameter int unsigned Width = 10,
  parameter int unsigned Max   = 999
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [Width-1:0] count
);

  logic [Width-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (inc && (count_q != Width'(Max))) begin
      count_q <= count_q + Width'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/typing_tracker.sv
// typing_tracker: keeps the player's typed buffer against a target word, the
// matching-prefix length used for highlighting, and saturating word/error tallies.
// Ports: clk, rst_n (async active-low), bus (typing_tracker_if.slave).
// All outputs are registered; one key or load is processed per cycle.
module typing_tracker
  import typeracer_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  typing_tracker_if.slave   bus
);

  state_e           state_q, state_d;
  text_t            typed_q, typed_d;
  text_t            target_q, target_d;
  logic [LEN_W-1:0] target_len_q, target_len_d;
  logic [TOT_W-1:0] tot_q, tot_d;
  logic [TOT_W-1:0] correct_q, correct_d;
  logic             word_ok_q, word_ok_d;
  logic             word_fail_q, word_fail_d;
  logic             words_inc, errors_inc;
  logic [CODE_W-1:0] target_char;
  logic             prefix_intact;

  // Only meaningful while tot_q < MAX_LEN; the letter path is gated on that.
  assign target_char   = target_q[tot_q * CODE_W +: CODE_W];
  assign prefix_intact = (correct_q == tot_q);

  always_comb begin
    state_d      = state_q;
    typed_d      = typed_q;
    target_d     = target_q;
    target_len_d = target_len_q;
    tot_d        = tot_q;
    correct_d    = correct_q;
    word_ok_d    = 1'b0;
    word_fail_d  = 1'b0;
    words_inc    = 1'b0;
    errors_inc   = 1'b0;

    if (bus.load) begin
      // Load wins over any key in the same cycle.
      target_d     = bus.target;
      target_len_d = bus.target_len;
      typed_d      = '0;
      tot_d        = '0;
      correct_d    = '0;
      state_d      = StTyping;
    end else if (bus.key_valid && (state_q == StTyping)) begin
      if (bus.key_enter) begin
        if ((tot_q == {1'b0, target_len_q}) && prefix_intact) begin
          word_ok_d = 1'b1;
          words_inc = 1'b1;
          state_d   = StIdle;
        end else begin
          word_fail_d = 1'b1;
        end
      end else if (bus.key_bs) begin
        if (tot_q != '0) begin
          typed_d[(tot_q - TOT_W'(1)) * CODE_W +: CODE_W] = BLANK;
          tot_d = tot_q - TOT_W'(1);
          if (prefix_intact) begin
            correct_d = correct_q - TOT_W'(1);
          end
        end
      end else if (is_letter(bus.key_code) && (tot_q < TOT_W'(MAX_LEN))) begin
        typed_d[tot_q * CODE_W +: CODE_W] = bus.key_code;
        tot_d = tot_q + TOT_W'(1);
        if (prefix_intact) begin
          // Only the first divergence from a clean prefix counts as an error.
          if (bus.key_code == target_char) begin
            correct_d = correct_q + TOT_W'(1);
          end else begin
            errors_inc = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      typed_q      <= '0;
      target_q     <= '0;
      target_len_q <= '0;
      tot_q        <= '0;
      correct_q    <= '0;
      word_ok_q    <= 1'b0;
      word_fail_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      typed_q      <= typed_d;
      target_q     <= target_d;
      target_len_q <= target_len_d;
      tot_q        <= tot_d;
      correct_q    <= correct_d;
      word_ok_q    <= word_ok_d;
      word_fail_q  <= word_fail_d;
    end
  end

  sat_counter #(
    .Width (CNT_W),
    .Max   (CNT_MAX)
  ) u_words_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (words_inc),
    .count (bus.words)
  );

  sat_counter #(
    .Width (CNT_W),
    .Max   (CNT_MAX)
  ) u_errors_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (errors_inc),
    .count (bus.errors)
  );

  assign bus.typed     = typed_q;
  assign bus.tot       = tot_q;
  assign bus.correct   = correct_q;
  assign bus.word_ok   = word_ok_q;
  assign bus.word_fail = word_fail_q;
  assign bus.active    = (state_q == StTyping);

endmodule
